// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, constants and bit-order helpers for the SPI shift engine
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] DEFAULT_DUMMY_BYTE = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Bit presented on MISO for the current transmit shift register.
  function automatic logic out_bit(input logic [SPI_BYTE_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[SPI_BYTE_W-1];
  endfunction

  // Transmit shift: move the next bit toward the output end, back-filling with 1.
  function automatic logic [SPI_BYTE_W-1:0] tx_advance(input logic [SPI_BYTE_W-1:0] v,
                                                       input logic lsb);
    return lsb ? {1'b1, v[SPI_BYTE_W-1:1]} : {v[SPI_BYTE_W-2:0], 1'b1};
  endfunction

  // Receive shift: insert the sampled bit at the end matching the bit order.
  function automatic logic [SPI_BYTE_W-1:0] rx_insert(input logic [SPI_BYTE_W-1:0] v,
                                                      input logic lsb, input logic b);
    return lsb ? {b, v[SPI_BYTE_W-1:1]} : {v[SPI_BYTE_W-2:0], b};
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - multi-stage 1-bit synchroniser with enable for the MOSI input
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ena_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain while enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else if (ena_i) begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - byte-level SPI slave datapath driven by edge-detector strobes
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] DUMMY_BYTE  = DEFAULT_DUMMY_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  spi_ss,
  input  logic                  spi_in,
  output logic                  spi_out,
  input  logic                  spi_clk_phase,
  input  logic                  lsb_first,
  input  logic                  sample_stb,
  input  logic                  shift_stb,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  underrun
);

  logic din_s;

  spi_state_e            state_q, state_d;
  logic                  ss_q, ss_prev_q;
  logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [2:0]            rx_cnt_q, rx_cnt_d;
  logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic [2:0]            tx_cnt_q, tx_cnt_d;
  logic                  skip_q, skip_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [SPI_BYTE_W-1:0] txbuf_q, txbuf_d;
  logic                  txbuf_full_q, txbuf_full_d;
  logic                  spi_out_q, spi_out_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;

  logic                  ss_fall;
  logic                  rx_take;
  logic                  tx_wr;
  logic                  tx_load;
  logic [SPI_BYTE_W-1:0] rx_next;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_in_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .ena_i (ena),
    .d_i   (spi_in),
    .q_o   (din_s)
  );

  assign ss_fall = ss_prev_q & ~ss_q;
  assign rx_take = rx_valid_q & rx_ready;
  assign tx_wr   = tx_valid & ~txbuf_full_q;
  assign rx_next = rx_insert(rx_shift_q, lsb_first, din_s);

  // Frame FSM, bit counters, receive completion and transmit buffer next-state.
  always_comb begin
    state_d      = state_q;
    rx_shift_d   = rx_shift_q;
    rx_cnt_d     = rx_cnt_q;
    tx_shift_d   = tx_shift_q;
    tx_cnt_d     = tx_cnt_q;
    skip_d       = skip_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    txbuf_d      = txbuf_q;
    txbuf_full_d = txbuf_full_q;
    overrun_d    = 1'b0;
    underrun_d   = 1'b0;
    tx_load      = 1'b0;

    if (rx_take) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        rx_cnt_d = '0;
        tx_cnt_d = '0;
        if (ss_fall) begin
          state_d = ACTIVE;
          tx_load = 1'b1;
          skip_d  = spi_clk_phase;
        end
      end
      ACTIVE: begin
        if (ss_q) begin
          // Deselect: any partial byte in either direction is abandoned.
          state_d    = IDLE;
          rx_cnt_d   = '0;
          tx_cnt_d   = '0;
          skip_d     = 1'b0;
          rx_shift_d = '0;
        end else begin
          if (sample_stb) begin
            rx_shift_d = rx_next;
            rx_cnt_d   = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) begin
              if (!rx_valid_q || rx_take) begin
                rx_data_d  = rx_next;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end
          if (shift_stb) begin
            if (skip_q) begin
              // CPHA1: the first leading edge only presents the first bit.
              skip_d = 1'b0;
            end else if (tx_cnt_q == 3'd7) begin
              tx_load  = 1'b1;
              tx_cnt_d = '0;
            end else begin
              tx_shift_d = tx_advance(tx_shift_q, lsb_first);
              tx_cnt_d   = tx_cnt_q + 3'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load sees the buffer as it was before any same-cycle write.
    if (tx_load) begin
      if (txbuf_full_q) begin
        tx_shift_d   = txbuf_q;
        txbuf_full_d = 1'b0;
      end else begin
        tx_shift_d = DUMMY_BYTE;
        underrun_d = 1'b1;
      end
    end
    if (tx_wr) begin
      txbuf_d      = tx_data;
      txbuf_full_d = 1'b1;
    end

    spi_out_d = (state_q == ACTIVE) ? out_bit(tx_shift_q, lsb_first) : 1'b1;
  end

  // State and datapath registers; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ss_q         <= 1'b1;
      ss_prev_q    <= 1'b1;
      rx_shift_q   <= '0;
      rx_cnt_q     <= '0;
      tx_shift_q   <= '0;
      tx_cnt_q     <= '0;
      skip_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      txbuf_q      <= '0;
      txbuf_full_q <= 1'b0;
      spi_out_q    <= 1'b1;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      ss_q         <= spi_ss;
      ss_prev_q    <= ss_q;
      rx_shift_q   <= rx_shift_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_shift_q   <= tx_shift_d;
      tx_cnt_q     <= tx_cnt_d;
      skip_q       <= skip_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      txbuf_q      <= txbuf_d;
      txbuf_full_q <= txbuf_full_d;
      spi_out_q    <= spi_out_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  assign spi_out  = spi_out_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~txbuf_full_q;
  assign busy     = (state_q == ACTIVE);
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - scoreboard bench for spi_shift_engine
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       rst, ena, spi_ss, spi_in, spi_out, spi_clk_phase, lsb_first;
  logic       sample_stb, shift_stb, rx_valid, rx_ready, tx_valid, tx_ready;
  logic       busy, overrun, underrun;
  logic [7:0] rx_data, tx_data;

  always #5 clk = ~clk;

  spi_shift_engine dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .spi_ss       (spi_ss),
    .spi_in       (spi_in),
    .spi_out      (spi_out),
    .spi_clk_phase(spi_clk_phase),
    .lsb_first    (lsb_first),
    .sample_stb   (sample_stb),
    .shift_stb    (shift_stb),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .overrun      (overrun),
    .underrun     (underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit         exp_bits[$];
  logic [7:0] exp_rx[$];
  int         exp_under = 0, exp_over = 0;
  int         seen_under = 0, seen_over = 0;
  bit         mon_en = 1'b0;
  bit         m_rx_full = 1'b0;

  logic [7:0] f_mosi[4];
  logic [7:0] f_tx[5];
  bit         f_sup[5];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endfunction

  // Monitor: compares MISO at every sample strobe and rx bytes at every handshake.
  always @(negedge clk) begin
    #1;
    if (mon_en && ena && rst) begin
      if (sample_stb && busy) begin
        if (exp_bits.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL miso_unexpected: got %0b expected nothing", spi_out);
        end else begin
          check("miso_bit", {31'd0, spi_out}, {31'd0, exp_bits.pop_front()});
        end
      end
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rx_unexpected: got %0h expected nothing", rx_data);
        end else begin
          check("rx_byte", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
        end
      end
      if (underrun) seen_under++;
      if (overrun) seen_over++;
    end
  end

  task automatic tx_write(input logic [7:0] d);
    bit ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (tx_ready) ok = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL tx_write_timeout: got tx_ready 0 expected 1");
    end
  endtask

  task automatic pulse_sample();
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_shift();
    shift_stb = 1'b1;
    @(negedge clk);
    shift_stb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One frame; expectations come from byte-level rules, pushed as stimulus is issued.
  task automatic run_frame(input bit cpha, input bit lsb, input int n, input int abort_at,
                           input bit hold_rx);
    int         loads;
    int         s;
    bit         done;
    logic [7:0] v;
    logic [7:0] m;
    loads = (abort_at > 0) ? 1 : (cpha ? n : n + 1);
    for (int k = 0; k < loads; k++) if (!f_sup[k]) exp_under++;
    if (abort_at == 0) begin
      for (int j = 0; j < n; j++) begin
        if (!m_rx_full) begin
          exp_rx.push_back(f_mosi[j]);
          m_rx_full = hold_rx;
        end else begin
          exp_over++;
        end
      end
    end
    spi_clk_phase = cpha;
    lsb_first     = lsb;
    if (f_sup[0]) tx_write(f_tx[0]);
    spi_ss = 1'b0;
    repeat (5) @(negedge clk);
    check("tx_ready_after_start", {31'd0, tx_ready}, 32'd1);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    s    = 0;
    done = 1'b0;
    for (int j = 0; j < n && !done; j++) begin
      v = f_sup[j] ? f_tx[j] : 8'hFF;
      m = f_mosi[j];
      for (int i = 0; i < 8 && !done; i++) begin
        if (abort_at > 0 && s == abort_at) begin
          done = 1'b1;
        end else begin
          if (i == 3 && j + 1 < loads && f_sup[j+1]) tx_write(f_tx[j+1]);
          if (cpha) pulse_shift();
          exp_bits.push_back(lsb ? v[i] : v[7-i]);
          spi_in = lsb ? m[i] : m[7-i];
          repeat (4) @(negedge clk);
          pulse_sample();
          s++;
          if (!cpha) pulse_shift();
        end
      end
    end
    spi_ss = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("miso_queue_drained", exp_bits.size(), 32'd0);
    check("underrun_count", seen_under, exp_under);
    check("overrun_count", seen_over, exp_over);
    if (!hold_rx) check("rx_queue_drained", exp_rx.size(), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_spi_out", {31'd0, spi_out}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ena = 1'b1; spi_ss = 1'b1; spi_in = 1'b0;
    spi_clk_phase = 1'b0; lsb_first = 1'b0; sample_stb = 1'b0; shift_stb = 1'b0;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    // CPHA0 MSB-first, tx A5 / MOSI 3C
    f_tx[0] = 8'hA5; f_sup[0] = 1; f_sup[1] = 0; f_mosi[0] = 8'h3C;
    run_frame(1'b0, 1'b0, 1, 0, 1'b0);

    // CPHA1 LSB-first, tx 81 / MOSI 81
    f_tx[0] = 8'h81; f_sup[0] = 1; f_mosi[0] = 8'h81;
    run_frame(1'b1, 1'b1, 1, 0, 1'b0);

    // Underrun: nothing written, two bytes
    for (int k = 0; k < 5; k++) f_sup[k] = 0;
    f_mosi[0] = 8'h5A; f_mosi[1] = 8'hC3;
    run_frame(1'b0, 1'b0, 2, 0, 1'b0);

    // Overrun: consumer stalled across two bytes
    rx_ready = 1'b0;
    f_tx[0] = 8'h12; f_sup[0] = 1; f_tx[1] = 8'h34; f_sup[1] = 1; f_sup[2] = 0;
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22;
    run_frame(1'b0, 1'b0, 2, 0, 1'b1);
    check("overrun_rx_data_kept", {24'd0, rx_data}, 32'h11);
    check("overrun_rx_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready  = 1'b1;
    m_rx_full = 1'b0;
    repeat (3) @(negedge clk);
    check("overrun_rx_drained", exp_rx.size(), 32'd0);

    // Mid-byte abort after 3 samples, then a clean F0 frame
    f_tx[0] = 8'h6E; f_sup[0] = 1; f_mosi[0] = 8'hAA;
    run_frame(1'b0, 1'b0, 1, 3, 1'b0);
    check("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    f_tx[0] = 8'h0F; f_sup[0] = 1; f_sup[1] = 0; f_mosi[0] = 8'hF0;
    run_frame(1'b0, 1'b0, 1, 0, 1'b0);

    // Randomised frames
    for (int r = 0; r < 8; r++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int k = 0; k < 5; k++) begin
        f_tx[k]  = 8'($urandom);
        f_sup[k] = ($urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < 4; k++) f_mosi[k] = 8'($urandom);
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nb, 0, 1'b0);
    end

    // ena gating mid-frame, then reset mid-frame
    mon_en = 1'b0;
    spi_clk_phase = 1'b0; lsb_first = 1'b0;
    tx_write(8'h5A);
    spi_ss = 1'b0;
    repeat (6) @(negedge clk);
    check("gate_pre_busy", {31'd0, busy}, 32'd1);
    check("gate_pre_spi_out", {31'd0, spi_out}, 32'd0);
    ena = 1'b0;
    spi_ss = 1'b1;
    spi_in = 1'b1;
    tx_data = 8'h77; tx_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      sample_stb = 1'b1; shift_stb = 1'b1;
      @(negedge clk);
    end
    sample_stb = 1'b0; shift_stb = 1'b0; tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("gate_busy_held", {31'd0, busy}, 32'd1);
    check("gate_spi_out_held", {31'd0, spi_out}, 32'd0);
    check("gate_rx_valid_held", {31'd0, rx_valid}, 32'd0);
    check("gate_tx_ready_held", {31'd0, tx_ready}, 32'd1);
    check("gate_underrun_quiet", {31'd0, underrun}, 32'd0);
    spi_ss = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    check("gate_resume_busy", {31'd0, busy}, 32'd1);
    check("gate_resume_tx_ready", {31'd0, tx_ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    spi_ss = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
